// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full/almost-full flags, occupancy count and sticky overflow
// for an async FIFO; includes the 2-flop synchroniser for the incoming read pointer.
module fifo_wptr_full #(
  parameter int unsigned ADDR_SIZE    = 4,
  parameter int unsigned AFULL_THRESH = 14
) (
  input  logic                 wr_clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE:0]   rd_ptr_gray,
  input  logic                 overflow_clr,
  output logic [ADDR_SIZE-1:0] wr_addr,
  output logic [ADDR_SIZE:0]   wr_ptr_gray,
  output logic                 full,
  output logic                 almost_full,
  output logic [ADDR_SIZE:0]   wr_data_count,
  output logic                 wr_ack,
  output logic                 overflow
);

  localparam int unsigned PW = ADDR_SIZE + 1;
  localparam logic [ADDR_SIZE:0] AFULL_T = PW'(AFULL_THRESH);

  logic [ADDR_SIZE:0] wbin;
  logic [ADDR_SIZE:0] wbin_next;
  logic [ADDR_SIZE:0] gray_next;
  logic [ADDR_SIZE:0] rq1;
  logic [ADDR_SIZE:0] rq2;
  logic [ADDR_SIZE:0] rbin;
  logic [ADDR_SIZE:0] full_gray;
  logic [ADDR_SIZE:0] count_next;
  logic               push;

  assign push      = wr_en & ~full;
  assign wbin_next = wbin + PW'(push);
  assign gray_next = wbin_next ^ (wbin_next >> 1);
  assign wr_addr   = wbin[ADDR_SIZE-1:0];

  // Full when the write pointer is one lap ahead: top two Gray bits inverted.
  assign full_gray = {~rq2[ADDR_SIZE:ADDR_SIZE-1], rq2[ADDR_SIZE-2:0]};

  always_comb begin
    rbin = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      rbin[i] = ^(rq2 >> i);
    end
  end

  assign count_next = wbin_next - rbin;

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      wbin          <= '0;
      wr_ptr_gray   <= '0;
      rq1           <= '0;
      rq2           <= '0;
      full          <= 1'b0;
      almost_full   <= 1'b0;
      wr_data_count <= '0;
      wr_ack        <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      wbin          <= wbin_next;
      wr_ptr_gray   <= gray_next;
      rq1           <= rd_ptr_gray;
      rq2           <= rq1;
      full          <= (gray_next == full_gray);
      almost_full   <= (count_next >= AFULL_T);
      wr_data_count <= count_next;
      wr_ack        <= push;
      overflow      <= (overflow & ~overflow_clr) | (wr_en & full);
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full: stimulus pushes expected outputs per edge,
// a monitor pops and compares them shortly after each rising edge.
module tb_fifo_wptr_full;

  logic       wr_clk;
  logic       rst;
  logic       wr_en;
  logic [4:0] rd_ptr_gray;
  logic       overflow_clr;
  logic [3:0] wr_addr;
  logic [4:0] wr_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_data_count;
  logic       wr_ack;
  logic       overflow;

  fifo_wptr_full #(.ADDR_SIZE(4), .AFULL_THRESH(14)) dut (
    .wr_clk        (wr_clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .rd_ptr_gray   (rd_ptr_gray),
    .overflow_clr  (overflow_clr),
    .wr_addr       (wr_addr),
    .wr_ptr_gray   (wr_ptr_gray),
    .full          (full),
    .almost_full   (almost_full),
    .wr_data_count (wr_data_count),
    .wr_ack        (wr_ack),
    .overflow      (overflow)
  );

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  typedef struct {
    int tag;
    int addr;
    int gray;
    int full;
    int af;
    int count;
    int ack;
    int ovf;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int total = 0;
  int bad   = 0;

  function automatic void chk(input int tag, input string what, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL step%0d %s actual=%0d expected=%0d", tag, what, act, exp);
    end
  endfunction

  function automatic int g(input int b);
    int m;
    m = b & 31;
    return m ^ (m >> 1);
  endfunction

  function automatic exp_t mk(input int tag, input int addr, input int gray, input int f,
                              input int af, input int count, input int ack, input int ovf);
    exp_t e;
    e.tag = tag; e.addr = addr; e.gray = gray; e.full = f;
    e.af = af; e.count = count; e.ack = ack; e.ovf = ovf;
    return e;
  endfunction

  task automatic step(input bit we, input bit clr, input bit r, input int rd, input exp_t e);
    @(negedge wr_clk);
    rst          = r;
    wr_en        = we;
    overflow_clr = clr;
    rd_ptr_gray  = 5'(rd);
    sb.push_back(e);
  endtask

  always @(posedge wr_clk) begin
    #1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      chk(cur.tag, "wr_addr",       int'(wr_addr),       cur.addr);
      chk(cur.tag, "wr_ptr_gray",   int'(wr_ptr_gray),   cur.gray);
      chk(cur.tag, "full",          int'(full),          cur.full);
      chk(cur.tag, "almost_full",   int'(almost_full),   cur.af);
      chk(cur.tag, "wr_data_count", int'(wr_data_count), cur.count);
      chk(cur.tag, "wr_ack",        int'(wr_ack),        cur.ack);
      chk(cur.tag, "overflow",      int'(overflow),      cur.ovf);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb;
    int cnt;
    rst = 1'b1; wr_en = 1'b0; overflow_clr = 1'b0; rd_ptr_gray = '0;

    // Held in reset with wr_en toggling
    for (int i = 0; i < 4; i++) step(i[0], 1'b0, 1'b1, 0, mk(1, 0, 0, 0, 0, 0, 0, 0));

    // Release and fill 16 slots with the read pointer parked at 0
    for (int k = 1; k <= 16; k++)
      step(1'b1, 1'b0, 1'b0, 0, mk(100 + k, k % 16, g(k), int'(k == 16), int'(k >= 14), k, 1, 0));
    step(1'b0, 1'b0, 1'b0, 0, mk(200, 0, 24, 1, 1, 16, 0, 0));

    // Rejected writes while full, then clear behaviour
    step(1'b1, 1'b0, 1'b0, 0, mk(210, 0, 24, 1, 1, 16, 0, 1));
    step(1'b1, 1'b0, 1'b0, 0, mk(211, 0, 24, 1, 1, 16, 0, 1));
    step(1'b1, 1'b1, 1'b0, 0, mk(212, 0, 24, 1, 1, 16, 0, 1));
    step(1'b0, 1'b1, 1'b0, 0, mk(213, 0, 24, 1, 1, 16, 0, 0));
    step(1'b0, 1'b0, 1'b0, 0, mk(214, 0, 24, 1, 1, 16, 0, 0));

    // Read pointer jumps to bin 4; visible on the third edge
    step(1'b0, 1'b0, 1'b0, 6, mk(220, 0, 24, 1, 1, 16, 0, 0));
    step(1'b0, 1'b0, 1'b0, 6, mk(221, 0, 24, 1, 1, 16, 0, 0));
    step(1'b0, 1'b0, 1'b0, 6, mk(222, 0, 24, 0, 0, 12, 0, 0));

    // 40 writes with read pointer trailing, crossing the 31->0 wrap
    wb = 16;
    for (int t = 1; t <= 40; t++) begin
      cnt = (t == 1) ? 13 : 14;
      step(1'b1, 1'b0, 1'b0, g(wb - 11),
           mk(300 + t, (wb + 1) % 16, g(wb + 1), 0, int'(cnt >= 14), cnt, 1, 0));
      wb = wb + 1;
    end

    // Burst interrupted by an asynchronous reset between edges
    for (int t = 1; t <= 2; t++) begin
      step(1'b1, 1'b0, 1'b0, g(wb - 11), mk(400 + t, (wb + 1) % 16, g(wb + 1), 0, 1, 14, 1, 0));
      wb = wb + 1;
    end
    @(posedge wr_clk);
    #3;
    rst = 1'b1;
    #1;
    chk(450, "async wr_addr",       int'(wr_addr),       0);
    chk(450, "async wr_ptr_gray",   int'(wr_ptr_gray),   0);
    chk(450, "async full",          int'(full),          0);
    chk(450, "async almost_full",   int'(almost_full),   0);
    chk(450, "async wr_data_count", int'(wr_data_count), 0);
    chk(450, "async wr_ack",        int'(wr_ack),        0);
    chk(450, "async overflow",      int'(overflow),      0);

    step(1'b1, 1'b0, 1'b1, 0, mk(460, 0, 0, 0, 0, 0, 0, 0));
    step(1'b1, 1'b0, 1'b1, 0, mk(461, 0, 0, 0, 0, 0, 0, 0));
    step(1'b1, 1'b0, 1'b0, 0, mk(470, 1, 1, 0, 0, 1, 1, 0));
    step(1'b1, 1'b0, 1'b0, 0, mk(471, 2, 3, 0, 0, 2, 1, 0));
    step(1'b0, 1'b0, 1'b0, 0, mk(472, 2, 3, 0, 0, 2, 0, 0));

    @(posedge wr_clk);
    #2;
    chk(500, "scoreboard_left", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
